// File: rtl/muldiv_sequencer_if.sv
// Request/response bundle between the decode stage and the multiply/divide sequencer.
// The master side issues requests and HI/LO moves; the slave side owns HI/LO.
interface muldiv_sequencer_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        abort;
    logic        mthi;
    logic        mtlo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    modport master (
        output start, op, a, b, abort, mthi, mtlo,
        input  hi, lo, busy, done
    );

    modport slave (
        input  start, op, a, b, abort, mthi, mtlo,
        output hi, lo, busy, done
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO: one shared 32-bit adder,
// 32 shift-add or restoring-divide steps, then a sign fix-up cycle.
module muldiv_sequencer (
    input  logic              clk,
    input  logic              reset,
    muldiv_sequencer_if.slave bus
);
    localparam int         ITER = 32;
    localparam logic [4:0] LAST = 5'(ITER - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SIGN = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [4:0]  r_cnt;
    logic        r_is_div;
    logic [31:0] r_mcand;
    logic [31:0] r_upper;
    logic [31:0] r_lower;
    logic [31:0] r_a_orig;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_divz;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_done;

    logic        w_accept;
    logic        w_iter;
    logic        w_write;
    logic        w_mthi_we;
    logic        w_mtlo_we;

    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic        w_signed;

    logic [32:0] w_rem_sh;
    logic [31:0] w_add_x;
    logic [31:0] w_add_y;
    logic        w_add_cin;
    logic [32:0] w_sum;
    logic        w_fits;

    logic [63:0] w_prod;
    logic [63:0] w_prod_fix;
    logic [31:0] w_quot_fix;
    logic [31:0] w_rem_fix;
    logic [31:0] w_hi_res;
    logic [31:0] w_lo_res;

    assign w_signed = bus.op[0];
    assign w_abs_a  = (w_signed && bus.a[31]) ? (~bus.a + 32'd1) : bus.a;
    assign w_abs_b  = (w_signed && bus.b[31]) ? (~bus.b + 32'd1) : bus.b;

    // Divide reuses the adder as a subtractor (~divisor + 1); the bit shifted
    // out of the remainder decides "fits" together with the carry.
    assign w_rem_sh  = {r_upper, r_lower[31]};
    assign w_add_x   = r_is_div ? w_rem_sh[31:0] : r_upper;
    assign w_add_y   = r_is_div ? ~r_mcand : (r_lower[0] ? r_mcand : 32'd0);
    assign w_add_cin = r_is_div;
    assign w_sum     = {1'b0, w_add_x} + {1'b0, w_add_y} + {32'd0, w_add_cin};
    assign w_fits    = w_rem_sh[32] | w_sum[32];

    assign w_prod     = {r_upper, r_lower};
    assign w_prod_fix = r_neg_q ? (~w_prod + 64'd1) : w_prod;
    assign w_quot_fix = r_neg_q ? (~r_lower + 32'd1) : r_lower;
    assign w_rem_fix  = r_neg_r ? (~r_upper + 32'd1) : r_upper;

    always_comb begin
        w_hi_res = w_prod_fix[63:32];
        w_lo_res = w_prod_fix[31:0];
        if (r_is_div) begin
            if (r_divz) begin
                w_hi_res = r_a_orig;
                w_lo_res = 32'hFFFF_FFFF;
            end else begin
                w_hi_res = w_rem_fix;
                w_lo_res = w_quot_fix;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_iter       = 1'b0;
        w_write      = 1'b0;
        w_mthi_we    = 1'b0;
        w_mtlo_we    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_accept     = 1'b1;
                    w_state_next = RUN;
                end else begin
                    w_mthi_we = bus.mthi;
                    w_mtlo_we = bus.mtlo;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    w_state_next = IDLE;
                end else begin
                    w_iter = 1'b1;
                    if (r_cnt == LAST) begin
                        w_state_next = SIGN;
                    end
                end
            end
            SIGN: begin
                w_state_next = IDLE;
                if (!bus.abort) begin
                    w_write = 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt    <= 5'd0;
            r_is_div <= 1'b0;
            r_mcand  <= 32'd0;
            r_upper  <= 32'd0;
            r_lower  <= 32'd0;
            r_a_orig <= 32'd0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_divz   <= 1'b0;
        end else if (w_accept) begin
            r_cnt    <= 5'd0;
            r_is_div <= bus.op[1];
            r_upper  <= 32'd0;
            r_a_orig <= bus.a;
            r_neg_q  <= w_signed & (bus.a[31] ^ bus.b[31]);
            r_neg_r  <= w_signed & bus.a[31];
            r_divz   <= bus.op[1] & (bus.b == 32'd0);
            // Multiply: a is the multiplicand, b shifts through the low half.
            // Divide: b is the divisor, a shifts through the low half.
            if (bus.op[1]) begin
                r_mcand <= w_abs_b;
                r_lower <= w_abs_a;
            end else begin
                r_mcand <= w_abs_a;
                r_lower <= w_abs_b;
            end
        end else if (w_iter) begin
            r_cnt <= r_cnt + 5'd1;
            if (r_is_div) begin
                r_upper <= w_fits ? w_sum[31:0] : w_rem_sh[31:0];
                r_lower <= {r_lower[30:0], w_fits};
            end else begin
                r_upper <= w_sum[32:1];
                r_lower <= {w_sum[0], r_lower[31:1]};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hi   <= 32'd0;
            r_lo   <= 32'd0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_write;
            if (w_write) begin
                r_hi <= w_hi_res;
                r_lo <= w_lo_res;
            end else begin
                if (w_mthi_we) begin
                    r_hi <= bus.a;
                end
                if (w_mtlo_we) begin
                    r_lo <= bus.a;
                end
            end
        end
    end

    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
    assign bus.done = r_done;
    assign bus.busy = (r_state != IDLE);
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomised and directed checks of muldiv_sequencer against an arithmetic
// reference; results are queued at issue and matched by a done-driven monitor.
module tb_muldiv_sequencer;
    logic clk;
    logic reset;

    muldiv_sequencer_if bus ();

    muldiv_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          total;
    int          bad;
    int          done_seen;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endfunction

    // Reference: plain 64-bit arithmetic, MIPS truncating division.
    function automatic logic [63:0] ref_op(logic [1:0] o, logic [31:0] x, logic [31:0] y);
        longint      sx;
        longint      sy;
        longint      q;
        longint      r;
        logic [63:0] ux;
        logic [63:0] uy;
        ux = {32'd0, x};
        uy = {32'd0, y};
        sx = o[0] ? {{32{x[31]}}, x} : {32'd0, x};
        sy = o[0] ? {{32{y[31]}}, y} : {32'd0, y};
        if (!o[1]) begin
            if (o[0]) return 64'(sx * sy);
            return ux * uy;
        end
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    always @(negedge clk) begin
        if (bus.done) begin
            done_seen++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL done_unexpected: got done=1 want no result pending");
            end else begin
                mon_e = exp_q.pop_front();
                check("result_hi", {32'd0, bus.hi}, {32'd0, mon_e.hi});
                check("result_lo", {32'd0, bus.lo}, {32'd0, mon_e.lo});
            end
        end
    end

    // Issue one op and wait for done; optionally poke start/mthi/mtlo during RUN.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input int inject, input logic ab);
        logic [63:0] r;
        int          k;
        int          nb;
        r = ref_op(o, x, y);
        exp_q.push_back('{hi: r[63:32], lo: r[31:0]});
        m_hi = r[63:32];
        m_lo = r[31:0];
        bus.op    = o;
        bus.a     = x;
        bus.b     = y;
        bus.start = 1'b1;
        bus.abort = ab;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        k  = 0;
        nb = 0;
        while (!bus.done && k < 100) begin
            if (bus.busy) nb++;
            if (k == inject) begin
                bus.start = 1'b1;
                bus.op    = 2'b00;
                bus.a     = 32'h0000_0099;
                bus.b     = 32'h0000_0077;
                bus.mthi  = 1'b1;
                bus.mtlo  = 1'b1;
            end else begin
                bus.start = 1'b0;
                bus.mthi  = 1'b0;
                bus.mtlo  = 1'b0;
            end
            @(posedge clk);
            #1;
            k++;
        end
        bus.start = 1'b0;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        check("latency", 64'(k), 64'd33);
        check("busy_cycles", 64'(nb), 64'd33);
        check("busy_at_done", {63'd0, bus.busy}, 64'd0);
        check("arch_hilo", {bus.hi, bus.lo}, {m_hi, m_lo});
        $display("op=%0d a=%h b=%h -> hi=%h lo=%h lat=%0d", o, x, y, bus.hi, bus.lo, k);
    endtask

    task automatic move_to(input logic wh, input logic wl, input logic [31:0] v);
        bus.a    = v;
        bus.mthi = wh;
        bus.mtlo = wl;
        @(posedge clk);
        #1;
        bus.mthi = 1'b0;
        bus.mtlo = 1'b0;
        if (wh) m_hi = v;
        if (wl) m_lo = v;
        check("move_hilo", {bus.hi, bus.lo}, {m_hi, m_lo});
        $display("move hi=%0b lo=%0b v=%h -> hi=%h lo=%h", wh, wl, v, bus.hi, bus.lo);
    endtask

    initial begin
        int d0;
        total     = 0;
        bad       = 0;
        done_seen = 0;
        m_hi      = 32'd0;
        m_lo      = 32'd0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = 32'd0;
        bus.b     = 32'd0;
        bus.abort = 1'b0;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_hilo", {bus.hi, bus.lo}, 64'd0);
        check("reset_busy", {63'd0, bus.busy}, 64'd0);
        check("reset_done", {63'd0, bus.done}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b0);
        check("multu_max", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);
        run_op(2'b01, 32'hFFFF_FFFD, 32'd5, -1, 1'b0);
        check("mult_neg", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2, -1, 1'b0);
        check("div_neg", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(2'b10, 32'd100, 32'd0, -1, 1'b0);
        check("divu_zero", {bus.hi, bus.lo}, 64'h0000_0064_FFFF_FFFF);
        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0);
        check("div_wrap", {bus.hi, bus.lo}, 64'h0000_0000_8000_0000);

        move_to(1'b0, 1'b1, 32'h1234_5678);
        check("mtlo", {32'd0, bus.lo}, 64'h1234_5678);

        // Abort a MULTU 2x3 at iteration 10: no result, no done.
        bus.op    = 2'b00;
        bus.a     = 32'd2;
        bus.b     = 32'd3;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        d0 = done_seen;
        repeat (10) @(posedge clk);
        #1;
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        check("abort_busy", {63'd0, bus.busy}, 64'd0);
        repeat (40) @(posedge clk);
        #1;
        check("abort_no_done", 64'(done_seen - d0), 64'd0);
        check("abort_hilo", {bus.hi, bus.lo}, {m_hi, m_lo});
        $display("abort multu 2x3 -> hi=%h lo=%h", bus.hi, bus.lo);

        run_op(2'b10, 32'd10, 32'd3, 5, 1'b0);
        check("divu_ignored_req", {bus.hi, bus.lo}, 64'h0000_0001_0000_0003);

        // Asynchronous reset at iteration 20 of a MULT.
        bus.op    = 2'b01;
        bus.a     = 32'hFFFF_0001;
        bus.b     = 32'h0000_7777;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("midreset_hilo", {bus.hi, bus.lo}, 64'd0);
        check("midreset_busy", {63'd0, bus.busy}, 64'd0);
        check("midreset_done", {63'd0, bus.done}, 64'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        $display("reset during mult -> hi=%h lo=%h busy=%0b", bus.hi, bus.lo, bus.busy);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        run_op(2'b00, 32'd7, 32'd6, -1, 1'b0);
        check("multu_7x6", {bus.hi, bus.lo}, 64'd42);

        // Random back-to-back traffic with occasional HI/LO moves and abort-with-start.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                move_to(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
            end
            run_op(2'($urandom_range(0, 3)), rnd_val(), rnd_val(),
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 32)) : -1,
                   1'($urandom_range(0, 5) == 0));
        end

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
